// File: rtl/store_narrow.sv
// store_narrow: sub-word store unit turning byte/halfword/word stores into lane-enabled bus writes.
// Define STORE_SPLIT_EN to split misaligned stores into two word writes instead of faulting.
module store_narrow (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        st_done,
  output logic        st_fault
);
  typedef enum logic [1:0] {IDLE, WR1, WR2, RESP} state_t;
  state_t state_q, state_d;
  logic ready_q, ready_d, we_q, we_d, done_q, done_d, fault_q, fault_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0] be_q, be_d, be2_q, be2_d;
  logic [1:0] off;
  logic mis, bad;
  logic [3:0] be_al, be1, be2;
  logic [31:0] wd_al, wd;
  assign off = st_addr[1:0];
  assign mis = (st_size == 2'b01 && off[0]) || (st_size == 2'b10 && off != 2'b00);
  assign be_al = st_size == 2'b00 ? 4'b0001 << off :
                 st_size == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd_al = st_size == 2'b00 ? {4{st_data[7:0]}} :
                 st_size == 2'b01 ? {2{st_data[15:0]}} : st_data;
`ifdef STORE_SPLIT_EN
  logic [7:0] sh;
  logic [31:0] rot;
  // high nibble of the shifted mask is the spill into the next word
  assign sh  = {4'b0000, st_size == 2'b01 ? 4'b0011 : 4'b1111} << off;
  assign rot = off == 2'd1 ? {st_data[23:0], st_data[31:24]} :
               off == 2'd2 ? {st_data[15:0], st_data[31:16]} :
               off == 2'd3 ? {st_data[7:0], st_data[31:8]} : st_data;
  assign bad = st_size == 2'b11;
  assign be1 = mis ? sh[3:0] : be_al;
  assign be2 = mis ? sh[7:4] : 4'b0000;
  assign wd  = mis ? rot : wd_al;
`else
  assign bad = st_size == 2'b11 || mis;
  assign be1 = be_al;
  assign be2 = 4'b0000;
  assign wd  = wd_al;
`endif
  assign st_ready  = ready_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign st_done   = done_q;
  assign st_fault  = fault_q;
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    be2_d   = be2_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      IDLE: if (st_valid && ready_q) begin
        if (bad) begin
          state_d = RESP;
          fault_d = 1'b1;
        end else begin
          state_d = WR1;
          we_d    = 1'b1;
          addr_d  = {st_addr[31:2], 2'b00};
          be_d    = be1;
          be2_d   = be2;
          wdata_d = wd;
        end
      end
      WR1: if (we_q && mem_ack) begin
        we_d = 1'b0;
        if (be2_q != 4'b0000) begin
          state_d = WR2;
          addr_d  = addr_q + 32'd4;
          be_d    = be2_q;
        end else begin
          state_d = RESP;
          done_d  = 1'b1;
        end
      end
      // first WR2 cycle keeps the strobe low to separate the two writes
      WR2: if (!we_q) we_d = 1'b1;
           else if (mem_ack) begin
             we_d    = 1'b0;
             state_d = RESP;
             done_d  = 1'b1;
           end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      be2_q   <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      be2_q   <= be2_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
endmodule

// File: tb/tb_store_narrow.sv
// tb_store_narrow: directed stores with a write/response scoreboard checked by a separate monitor.
module tb_store_narrow;
  typedef struct packed {logic [31:0] a; logic [3:0] be; logic [31:0] d;} wr_t;
  logic clk = 0, rst_n = 0, st_valid = 0, mem_ack = 0;
  logic [1:0] st_size = 0;
  logic [31:0] st_addr = 0, st_data = 0;
  logic st_ready, mem_we, st_done, st_fault;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int nvec = 0, nmis = 0, cyc = 0, ack_delay = 0, wcnt = 0;
  bit force_ack = 0;
  wr_t wq[$];
  logic [1:0] rq[$];
  store_narrow dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .st_done(st_done), .st_fault(st_fault)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [67:0] act, input logic [67:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic wr_t mk(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    mk = '{a: a, be: be, d: d};
  endfunction
  // bus responder: ack after ack_delay strobe cycles
  initial forever begin
    @(negedge clk);
    if (rst_n && mem_we) begin
      mem_ack = wcnt == ack_delay;
      wcnt = mem_ack ? 0 : wcnt + 1;
    end else begin
      mem_ack = force_ack;
      wcnt = 0;
    end
  end
  // monitor: stability of held writes, scoreboard pops on ack and on response
  initial begin
    wr_t cur, e;
    bit in_wr = 0;
    logic [1:0] r;
    forever begin
      @(negedge clk);
      if (rst_n && mem_we) begin
        if (!in_wr) begin
          cur = {mem_addr, mem_be, mem_wdata};
          in_wr = 1;
        end else chk("write_stable", {mem_addr, mem_be, mem_wdata}, cur);
        if (mem_ack) begin
          in_wr = 0;
          if (wq.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            e = wq.pop_front();
            chk("write", {mem_addr, mem_be, mem_wdata}, e);
          end
        end
      end else in_wr = 0;
      if (st_done || st_fault) begin
        if (rq.size() == 0) chk("unexpected_resp", {st_done, st_fault}, 0);
        else begin
          r = rq.pop_front();
          chk("resp", {st_done, st_fault}, r);
        end
      end
    end
  end
  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                       input int dly, input int nw, input wr_t w1, input wr_t w2,
                       input logic [1:0] resp, input int lat);
    int hs;
    bit got = 0;
    if (nw > 0) wq.push_back(w1);
    if (nw > 1) wq.push_back(w2);
    rq.push_back(resp);
    ack_delay = dly;
    @(negedge clk);
    st_valid = 1; st_size = sz; st_addr = a; st_data = d;
    for (int i = 0; i < 20 && !st_ready; i++) @(negedge clk);
    if (!st_ready) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    st_valid = 0;
    hs = cyc;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (st_done || st_fault) begin got = 1; break; end
    end
    if (!got) chk("resp_timeout", 0, 1);
    else begin
      if (resp == 2'b01) chk("fault_no_we", mem_we, 0);
      chk("latency", cyc - hs + 1, lat);
      @(negedge clk);
      chk("ready_after", st_ready, 1);
    end
  endtask
  initial begin
    #2;
    chk("rst_outs", {mem_we, st_done, st_fault, mem_be, mem_addr, mem_wdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ready_post_rst", st_ready, 1);
    store(2'b00, 32'h1003, 32'h000000A5, 0, 1, mk(32'h1000, 4'b1000, 32'hA5A5A5A5), 0, 2'b10, 2);
    store(2'b01, 32'h2002, 32'h00001234, 3, 1, mk(32'h2000, 4'b1100, 32'h12341234), 0, 2'b10, 5);
    store(2'b10, 32'h4000, 32'hDEADBEEF, 1, 1, mk(32'h4000, 4'b1111, 32'hDEADBEEF), 0, 2'b10, 3);
    store(2'b00, 32'h5001, 32'h1234565A, 0, 1, mk(32'h5000, 4'b0010, 32'h5A5A5A5A), 0, 2'b10, 2);
    store(2'b01, 32'h6000, 32'hFFFFBEEF, 0, 1, mk(32'h6000, 4'b0011, 32'hBEEFBEEF), 0, 2'b10, 2);
    store(2'b11, 32'h0000, 32'h11111111, 0, 0, 0, 0, 2'b01, 1);
`ifdef STORE_SPLIT_EN
    store(2'b10, 32'h3001, 32'h11223344, 0, 2, mk(32'h3000, 4'b1110, 32'h22334411),
          mk(32'h3004, 4'b0001, 32'h22334411), 2'b10, 4);
    store(2'b01, 32'h7001, 32'h0000CAFE, 0, 1, mk(32'h7000, 4'b0110, 32'h00CAFE00), 0, 2'b10, 2);
    store(2'b10, 32'hFFFFFFFD, 32'hAABBCCDD, 0, 2, mk(32'hFFFFFFFC, 4'b1110, 32'hBBCCDDAA),
          mk(32'h00000000, 4'b0001, 32'hBBCCDDAA), 2'b10, 4);
    store(2'b01, 32'h8003, 32'h00001357, 1, 2, mk(32'h8000, 4'b1000, 32'h57000013),
          mk(32'h8004, 4'b0001, 32'h57000013), 2'b10, 6);
`else
    store(2'b10, 32'h3001, 32'h11223344, 0, 0, 0, 0, 2'b01, 1);
    store(2'b01, 32'h7001, 32'h0000CAFE, 0, 0, 0, 0, 2'b01, 1);
    store(2'b10, 32'hFFFFFFFD, 32'hAABBCCDD, 0, 0, 0, 0, 2'b01, 1);
    store(2'b01, 32'h8003, 32'h00001357, 0, 0, 0, 0, 2'b01, 1);
`endif
    force_ack = 1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ack_ignored", {mem_we, st_done, st_fault}, 0);
    end
    force_ack = 0;
    ack_delay = 1000;
    @(negedge clk);
    st_valid = 1; st_size = 2'b10; st_addr = 32'h9000; st_data = 32'h0BADF00D;
    for (int i = 0; i < 20 && !st_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    st_valid = 0;
    repeat (2) @(negedge clk);
    chk("wr1_pending_we", mem_we, 1);
    #1 rst_n = 0;
    #1 chk("rst_mid_outs", {mem_we, st_done, st_fault, mem_be, mem_addr, mem_wdata}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold", {mem_we, st_done, st_fault}, 0);
    end
    rst_n = 1;
    ack_delay = 0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst", {st_ready, mem_we, st_done, st_fault}, 4'b1000);
    end
    store(2'b00, 32'hA002, 32'h000000C3, 0, 1, mk(32'hA000, 4'b0100, 32'hC3C3C3C3), 0, 2'b10, 2);
    repeat (2) @(negedge clk);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
